// File: rtl/seg7_decoder.sv
// seg7_decoder: debounced 7-segment pattern to hex digit receiver; optional SEG7DEC_ONEHOT_EN adds a one-hot digit output
module seg7_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg,
  output logic [3:0]       value,
  output logic             valid,
  output logic             blank,
  output logic             err,
  output logic             new_pulse,
  output logic [CNT_W-1:0] dec_cnt,
  output logic [1:0]       state
`ifdef SEG7DEC_ONEHOT_EN
  ,
  output logic [15:0]      onehot
`endif
);
  localparam int RW = $clog2(STABLE_CYCLES);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES - 1);
  typedef enum logic [1:0] {BLANK, SETTLE, LOCKED, ERROR} state_t;
  state_t st, nxt;
  logic [6:0] seg_q;
  logic [RW-1:0] run_cnt;
  logic was_locked, changed, commit, is_blank, legal, pulse;
  logic [3:0] dig, nv;
  function automatic logic [4:0] decode(input logic [6:0] l);
    case (l)
      7'h3F: decode = {1'b1, 4'h0};
      7'h06: decode = {1'b1, 4'h1};
      7'h5B: decode = {1'b1, 4'h2};
      7'h4F: decode = {1'b1, 4'h3};
      7'h66: decode = {1'b1, 4'h4};
      7'h6D: decode = {1'b1, 4'h5};
      7'h7D: decode = {1'b1, 4'h6};
      7'h07: decode = {1'b1, 4'h7};
      7'h7F: decode = {1'b1, 4'h8};
      7'h6F: decode = {1'b1, 4'h9};
      7'h77: decode = {1'b1, 4'hA};
      7'h7C: decode = {1'b1, 4'hB};
      7'h39: decode = {1'b1, 4'hC};
      7'h5E: decode = {1'b1, 4'hD};
      7'h79: decode = {1'b1, 4'hE};
      7'h71: decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction
  assign state = st;
  // classify the sampled pattern and work out the next state, digit and strobe
  always_comb begin
    changed = seg != seg_q;
    commit = !changed && run_cnt == RUN_MAX - 1'b1;
    is_blank = seg_q == 7'h7F;
    {legal, dig} = decode(~seg_q);
    nxt = changed ? SETTLE : commit ? (is_blank ? BLANK : legal ? LOCKED : ERROR) : st;
    nv = (commit && nxt == LOCKED) ? dig : value;
    pulse = commit && nxt == LOCKED && (!was_locked || dig != value);
  end
  // sampling, run counting, FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= 7'h7F;
      run_cnt <= '0;
      st <= BLANK;
      value <= 4'h0;
      valid <= 1'b0;
      blank <= 1'b1;
      err <= 1'b0;
      new_pulse <= 1'b0;
      dec_cnt <= '0;
      was_locked <= 1'b0;
`ifdef SEG7DEC_ONEHOT_EN
      onehot <= 16'h0000;
`endif
    end else begin
      seg_q <= seg;
      run_cnt <= changed ? '0 : run_cnt == RUN_MAX ? run_cnt : run_cnt + 1'b1;
      st <= nxt;
      value <= nv;
      valid <= nxt == LOCKED;
      blank <= nxt == BLANK;
      err <= nxt == ERROR;
      new_pulse <= pulse;
      if (pulse) dec_cnt <= dec_cnt + 1'b1;
      if (commit) was_locked <= nxt == LOCKED;
`ifdef SEG7DEC_ONEHOT_EN
      onehot <= nxt == LOCKED ? 16'h0001 << nv : 16'h0000;
`endif
    end
  end
endmodule

// File: tb/tb_seg7_decoder.sv
// tb_seg7_decoder: scoreboard bench; stimulus queues timestamped expected output changes, monitor checks them
module tb_seg7_decoder;
  logic clk = 0, rst = 1;
  logic [6:0] seg = 7'h7F;
  logic [3:0] value;
  logic valid, blank, err, new_pulse;
  logic [1:0] dec_cnt, state;
`ifdef SEG7DEC_ONEHOT_EN
  logic [15:0] onehot;
`endif
  seg7_decoder #(.STABLE_CYCLES(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .seg(seg), .value(value), .valid(valid), .blank(blank),
    .err(err), .new_pulse(new_pulse), .dec_cnt(dec_cnt), .state(state)
`ifdef SEG7DEC_ONEHOT_EN
    , .onehot(onehot)
`endif
  );
  typedef struct packed {
    int c;
    logic [1:0] st;
    logic [3:0] v;
    logic np;
    logic [1:0] dc;
  } ev_t;
  ev_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  logic started = 0;
  logic [8:0] prev = '0;
  always #5 clk = ~clk;
  // edge counter: at the negedge after edge n it reads n
  always @(posedge clk) begin
    cyc <= cyc + 1;
    started <= 1'b1;
  end
  // monitor: flag consistency each cycle, and every output change must match the next queued expectation
  always @(negedge clk) if (started) begin
    logic [8:0] cur;
    ev_t e, a;
    cur = {state, value, new_pulse, dec_cnt};
    n_cmp++;
    if ({valid, blank, err} !== {state == 2'd2, state == 2'd0, state == 2'd3}) begin
      n_bad++;
      $display("FAIL flags cyc=%0d got vbe=%b%b%b state=%0d", cyc, valid, blank, err, state);
    end
`ifdef SEG7DEC_ONEHOT_EN
    n_cmp++;
    if (onehot !== (valid ? 16'h0001 << value : 16'h0000)) begin
      n_bad++;
      $display("FAIL onehot cyc=%0d got %h value=%0d valid=%b", cyc, onehot, value, valid);
    end
`endif
    if (cur !== prev) begin
      a = {cyc, cur};
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got st=%0d v=%h np=%b dc=%0d, required no change", cyc, state, value, new_pulse, dec_cnt);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL event got cyc=%0d st=%0d v=%h np=%b dc=%0d required cyc=%0d st=%0d v=%h np=%b dc=%0d",
                   a.c, a.st, a.v, a.np, a.dc, e.c, e.st, e.v, e.np, e.dc);
        end
      end
    end
    prev = cur;
  end
  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input int c, input logic [1:0] s, input logic [3:0] v, input logic np, input logic [1:0] dc);
    q.push_back({c, s, v, np, dc});
  endtask
  task automatic apply(input logic [6:0] p, output int k);
    k = cyc + 1;
    seg = p;
  endtask
  initial begin
    int k, pv;
    logic [1:0] pdc;
    logic [1:0] exp_dc [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    wait_n(3);
    rst = 0;
    wait_n(10);
    apply(7'h79, k);
    push(k, 1, 4'h0, 0, 0);
    push(k + 3, 2, 4'h1, 1, 1);
    push(k + 4, 2, 4'h1, 0, 1);
    wait_n(8);
    apply(7'h40, k);
    push(k, 1, 4'h1, 0, 1);
    push(k + 3, 2, 4'h0, 1, 2);
    push(k + 4, 2, 4'h0, 0, 2);
    wait_n(8);
    apply(7'h00, k);
    push(k, 1, 4'h0, 0, 2);
    wait_n(1);
    seg = 7'h40;
    push(k + 4, 2, 4'h0, 0, 2);
    wait_n(8);
    apply(7'h7E, k);
    push(k, 1, 4'h0, 0, 2);
    push(k + 3, 3, 4'h0, 0, 2);
    wait_n(8);
    apply(7'h79, k);
    push(k, 1, 4'h0, 0, 2);
    wait_n(2);
    for (int i = 1; i < 10; i++) begin
      seg = i[0] ? 7'h40 : 7'h79;
      wait_n(2);
    end
    rst = 1;
    seg = 7'h7F;
    push(cyc + 1, 0, 4'h0, 0, 0);
    wait_n(2);
    rst = 0;
    wait_n(3);
    pv = 0;
    pdc = 0;
    for (int i = 0; i < 5; i++) begin
      apply(i[0] ? 7'h30 : 7'h24, k);
      push(k, 1, 4'(pv), 0, pdc);
      push(k + 3, 2, i[0] ? 4'h3 : 4'h2, 1, exp_dc[i]);
      push(k + 4, 2, i[0] ? 4'h3 : 4'h2, 0, exp_dc[i]);
      pv = i[0] ? 3 : 2;
      pdc = exp_dc[i];
      wait_n(7);
    end
    apply(7'h79, k);
    push(k, 1, 4'h2, 0, 1);
    wait_n(2);
    rst = 1;
    seg = 7'h7F;
    push(k + 2, 0, 4'h0, 0, 0);
    wait_n(1);
    rst = 0;
    wait_n(6);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events got %0d left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
